// File: rtl/csr_arbiter_if.sv
// Two-master CSR bus bundle: master-side request/response signals for m0 and m1
// plus the shared address/data bus towards the OR-combined register blocks.
interface csr_arbiter_if;
  logic       m0_req, m0_lock, m0_we;
  logic [4:0] m0_a;
  logic [7:0] m0_di, m0_do;
  logic       m0_gnt, m0_rvalid, m0_preempt;

  logic       m1_req, m1_lock, m1_we;
  logic [4:0] m1_a;
  logic [7:0] m1_di, m1_do;
  logic       m1_gnt, m1_rvalid, m1_preempt;

  logic [4:0] csr_a;
  logic       csr_we;
  logic [7:0] csr_do, csr_di;

  modport master (
    output m0_req, m0_lock, m0_a, m0_we, m0_di,
    output m1_req, m1_lock, m1_a, m1_we, m1_di,
    output csr_di,
    input  m0_gnt, m0_do, m0_rvalid, m0_preempt,
    input  m1_gnt, m1_do, m1_rvalid, m1_preempt,
    input  csr_a, csr_we, csr_do
  );

  modport slave (
    input  m0_req, m0_lock, m0_a, m0_we, m0_di,
    input  m1_req, m1_lock, m1_a, m1_we, m1_di,
    input  csr_di,
    output m0_gnt, m0_do, m0_rvalid, m0_preempt,
    output m1_gnt, m1_do, m1_rvalid, m1_preempt,
    output csr_a, csr_we, csr_do
  );
endinterface

// File: rtl/csr_arbiter.sv
// Round-robin arbiter sharing the CSR bus between two masters, with bus lock for
// bursts and a hold limit that forces a handover when the other master waits too long.
module csr_arbiter #(
  parameter logic [7:0] MAX_HOLD = 8'd32
) (
  input logic          clk,
  input logic          rst,
  csr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

  owner_e     owner_q, owner_d;
  logic       last_srv_q, last_srv_d;
  logic [7:0] hold_q, hold_d;
  logic       m0_rvalid_q, m1_rvalid_q;
  logic [7:0] m0_do_q, m1_do_q;

  logic own0, own1, gnt0, gnt1;
  logic cur_req, cur_lock, oth_req, hold_hit;

  always_comb begin
    own0     = (owner_q == OWN0);
    own1     = (owner_q == OWN1);
    gnt0     = own0 & bus.m0_req;
    gnt1     = own1 & bus.m1_req;
    cur_req  = own1 ? bus.m1_req  : bus.m0_req;
    cur_lock = own1 ? bus.m1_lock : bus.m0_lock;
    oth_req  = own1 ? bus.m0_req  : bus.m1_req;
    // Last cycle the owner may keep the bus while the other master is waiting.
    hold_hit = (own0 | own1) && (MAX_HOLD != 8'd0) &&
               (hold_q == MAX_HOLD - 8'd1) && oth_req;
  end

  always_comb begin
    owner_d    = owner_q;
    last_srv_d = last_srv_q;
    hold_d     = hold_q;
    case (owner_q)
      IDLE: begin
        hold_d = 8'd0;
        if (bus.m0_req && bus.m1_req) owner_d = last_srv_q ? OWN0 : OWN1;
        else if (bus.m0_req)          owner_d = OWN0;
        else if (bus.m1_req)          owner_d = OWN1;
      end
      OWN0, OWN1: begin
        if (hold_hit || (!cur_lock && (!cur_req || oth_req)))
          owner_d = oth_req ? (own0 ? OWN1 : OWN0) : IDLE;
        if (owner_d != owner_q) begin
          last_srv_d = own1;
          hold_d     = 8'd0;
        end else if (oth_req && (hold_q != 8'hFF)) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        owner_d = IDLE;
        hold_d  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q     <= IDLE;
      last_srv_q  <= 1'b1;
      hold_q      <= 8'd0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_do_q     <= 8'd0;
      m1_do_q     <= 8'd0;
    end else begin
      owner_q     <= owner_d;
      last_srv_q  <= last_srv_d;
      hold_q      <= hold_d;
      m0_rvalid_q <= gnt0;
      m1_rvalid_q <= gnt1;
      if (gnt0) m0_do_q <= bus.csr_di;
      if (gnt1) m1_do_q <= bus.csr_di;
    end
  end

  // Bus is driven only by the granted master; otherwise it idles at zero.
  assign bus.csr_a      = gnt0 ? bus.m0_a  : (gnt1 ? bus.m1_a  : 5'd0);
  assign bus.csr_we     = gnt0 ? bus.m0_we : (gnt1 ? bus.m1_we : 1'b0);
  assign bus.csr_do     = gnt0 ? bus.m0_di : (gnt1 ? bus.m1_di : 8'd0);

  assign bus.m0_gnt     = gnt0;
  assign bus.m1_gnt     = gnt1;
  assign bus.m0_rvalid  = m0_rvalid_q;
  assign bus.m1_rvalid  = m1_rvalid_q;
  assign bus.m0_do      = m0_do_q;
  assign bus.m1_do      = m1_do_q;
  assign bus.m0_preempt = own0 & hold_hit;
  assign bus.m1_preempt = own1 & hold_hit;

endmodule

// File: tb/tb_csr_arbiter.sv
// Bench for csr_arbiter: two instances (MAX_HOLD 32 and 4) driven with identical
// stimulus, directed scenarios plus a random run against a cycle-level reference model.
module tb_csr_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] req, lock, we;
  logic [4:0] a  [2];
  logic [7:0] di [2];
  logic [7:0] csr_di;

  int n_chk  = 0;
  int n_fail = 0;

  csr_arbiter_if ifa ();
  csr_arbiter_if ifb ();

  csr_arbiter #(.MAX_HOLD(8'd32)) dut32 (.clk(clk), .rst(rst), .bus(ifa));
  csr_arbiter #(.MAX_HOLD(8'd4))  dut4  (.clk(clk), .rst(rst), .bus(ifb));

  assign ifa.m0_req = req[0];  assign ifa.m0_lock = lock[0]; assign ifa.m0_we = we[0];
  assign ifa.m0_a   = a[0];    assign ifa.m0_di   = di[0];
  assign ifa.m1_req = req[1];  assign ifa.m1_lock = lock[1]; assign ifa.m1_we = we[1];
  assign ifa.m1_a   = a[1];    assign ifa.m1_di   = di[1];
  assign ifa.csr_di = csr_di;
  assign ifb.m0_req = req[0];  assign ifb.m0_lock = lock[0]; assign ifb.m0_we = we[0];
  assign ifb.m0_a   = a[0];    assign ifb.m0_di   = di[0];
  assign ifb.m1_req = req[1];  assign ifb.m1_lock = lock[1]; assign ifb.m1_we = we[1];
  assign ifb.m1_a   = a[1];    assign ifb.m1_di   = di[1];
  assign ifb.csr_di = csr_di;

  // Observed outputs, index 0 = MAX_HOLD 32 instance, 1 = MAX_HOLD 4 instance
  logic [1:0] o_gnt [2], o_rv [2], o_pre [2];
  logic [7:0] o_do  [2][2];
  logic [4:0] o_ca  [2];
  logic       o_we  [2];
  logic [7:0] o_cdo [2];

  always_comb begin
    o_gnt[0] = {ifa.m1_gnt, ifa.m0_gnt};         o_gnt[1] = {ifb.m1_gnt, ifb.m0_gnt};
    o_rv[0]  = {ifa.m1_rvalid, ifa.m0_rvalid};   o_rv[1]  = {ifb.m1_rvalid, ifb.m0_rvalid};
    o_pre[0] = {ifa.m1_preempt, ifa.m0_preempt}; o_pre[1] = {ifb.m1_preempt, ifb.m0_preempt};
    o_do[0][0] = ifa.m0_do; o_do[0][1] = ifa.m1_do;
    o_do[1][0] = ifb.m0_do; o_do[1][1] = ifb.m1_do;
    o_ca[0] = ifa.csr_a;   o_ca[1] = ifb.csr_a;
    o_we[0] = ifa.csr_we;  o_we[1] = ifb.csr_we;
    o_cdo[0] = ifa.csr_do; o_cdo[1] = ifb.csr_do;
  end

  // Reference model: owner is -1 (nobody), 0 or 1; wait is cycles the owner has held
  // the bus while the other master was asking for it.
  int         mh    [2];
  int         mown  [2];
  int         mlast [2];
  int         mwait [2];
  logic [1:0] mrv   [2];
  logic [7:0] mdo   [2][2];

  function automatic logic m_gnt(int d, int k);
    return (mown[d] == k) && req[k];
  endfunction

  function automatic logic m_pre(int d, int k);
    return (mown[d] == k) && (mh[d] != 0) && (mwait[d] == mh[d] - 1) && req[1-k];
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mown[d] = -1; mlast[d] = 1; mwait[d] = 0; mrv[d] = 2'b00;
        mdo[d][0] = 8'd0; mdo[d][1] = 8'd0;
      end else begin
        int  k, o;
        logic give_up;
        for (int m = 0; m < 2; m++) begin
          mrv[d][m] = m_gnt(d, m);
          if (m_gnt(d, m)) mdo[d][m] = csr_di;
        end
        if (mown[d] < 0) begin
          if (req == 2'b11)  mown[d] = 1 - mlast[d];
          else if (req[0])   mown[d] = 0;
          else if (req[1])   mown[d] = 1;
        end else begin
          k = mown[d];
          o = 1 - k;
          give_up = m_pre(d, k) || (!lock[k] && (!req[k] || req[o]));
          if (give_up) begin
            mown[d]  = req[o] ? o : -1;
            mlast[d] = k;
            mwait[d] = 0;
          end else if (req[o] && mwait[d] < 255) begin
            mwait[d]++;
          end
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    req = 2'b00; lock = 2'b00; we = 2'b00;
    a[0] = 5'd0; a[1] = 5'd0; di[0] = 8'd0; di[1] = 8'd0; csr_di = 8'd0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if ({o_gnt[d], o_rv[d], o_pre[d], o_we[d], o_ca[d], o_cdo[d], o_do[d][0], o_do[d][1]} !== 36'd0) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d got gnt=%b rv=%b pre=%b we=%b a=%h do=%h d0=%h d1=%h want all 0",
                 d, o_gnt[d], o_rv[d], o_pre[d], o_we[d], o_ca[d], o_cdo[d], o_do[d][0], o_do[d][1]);
      end
    end
  endtask

  task automatic test_read_latency();
    do_reset();
    req[0] = 1'b1; a[0] = 5'h03; we[0] = 1'b0; csr_di = 8'h20;
    @(negedge clk);
    n_chk++;
    if (o_gnt[0] !== 2'b00) begin n_fail++; $display("FAIL lat_idle_gnt got %b want 00", o_gnt[0]); end
    tick();
    @(negedge clk);
    n_chk++;
    if ({o_gnt[0], o_ca[0], o_we[0]} !== {2'b01, 5'h03, 1'b0}) begin
      n_fail++;
      $display("FAIL lat_gnt got gnt=%b a=%h we=%b want gnt=01 a=03 we=0", o_gnt[0], o_ca[0], o_we[0]);
    end
    tick();
    req[0] = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({o_rv[0], o_do[0][0], o_gnt[0]} !== {2'b01, 8'h20, 2'b00}) begin
      n_fail++;
      $display("FAIL lat_rdata got rv=%b do=%h gnt=%b want rv=01 do=20 gnt=00", o_rv[0], o_do[0][0], o_gnt[0]);
    end
    tick();
    @(negedge clk);
    n_chk++;
    if (o_rv[0] !== 2'b00) begin n_fail++; $display("FAIL lat_rv_pulse got %b want 00", o_rv[0]); end
  endtask

  task automatic test_alternate();
    logic [1:0] eg;
    logic [4:0] ea;
    do_reset();
    req = 2'b11; a[0] = 5'h01; a[1] = 5'h02;
    for (int c = 0; c < 7; c++) begin
      eg = (c == 0) ? 2'b00 : ((c % 2 == 1) ? 2'b01 : 2'b10);
      ea = (c == 0) ? 5'h00 : ((c % 2 == 1) ? 5'h01 : 5'h02);
      @(negedge clk);
      n_chk++;
      if ({o_gnt[0], o_ca[0]} !== {eg, ea}) begin
        n_fail++;
        $display("FAIL alt_cycle%0d got gnt=%b a=%h want gnt=%b a=%h", c, o_gnt[0], o_ca[0], eg, ea);
      end
      tick();
    end
    req = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_locked_burst();
    do_reset();
    req[1] = 1'b1; lock[1] = 1'b1; we[1] = 1'b1; a[1] = 5'h10; di[1] = 8'hA0;
    tick();
    for (int i = 0; i < 4; i++) begin
      req[0]  = 1'b1;
      a[1]    = 5'(16 + i);
      di[1]   = 8'(160 + i);
      lock[1] = (i < 3);
      @(negedge clk);
      n_chk++;
      if ({o_gnt[0], o_ca[0], o_we[0], o_cdo[0]} !== {2'b10, 5'(16 + i), 1'b1, 8'(160 + i)}) begin
        n_fail++;
        $display("FAIL burst_beat%0d got gnt=%b a=%h we=%b do=%h want gnt=10 a=%h we=1 do=%h",
                 i, o_gnt[0], o_ca[0], o_we[0], o_cdo[0], 5'(16 + i), 8'(160 + i));
      end
      tick();
    end
    req[1] = 1'b0; lock[1] = 1'b0; we[1] = 1'b0;
    @(negedge clk);
    n_chk++;
    if (o_gnt[0] !== 2'b01) begin n_fail++; $display("FAIL burst_m0_after_unlock got %b want 01", o_gnt[0]); end
    tick();
    req = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_hold_limit();
    logic [1:0] eg4, ep4;
    do_reset();
    req = 2'b11; lock[0] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      eg4 = (c == 0) ? 2'b00 : ((c < 5) ? 2'b01 : 2'b10);
      ep4 = (c == 4) ? 2'b01 : 2'b00;
      @(negedge clk);
      n_chk++;
      if ({o_gnt[1], o_pre[1]} !== {eg4, ep4}) begin
        n_fail++;
        $display("FAIL hold_cycle%0d got gnt=%b pre=%b want gnt=%b pre=%b", c, o_gnt[1], o_pre[1], eg4, ep4);
      end
      if (c == 5) begin
        n_chk++;
        if ({o_gnt[0], o_pre[0]} !== {2'b01, 2'b00}) begin
          n_fail++;
          $display("FAIL hold_long_limit got gnt=%b pre=%b want gnt=01 pre=00", o_gnt[0], o_pre[0]);
        end
      end
      tick();
    end
    req = 2'b00; lock = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    csr_di = 8'h5A; req[1] = 1'b1; lock[1] = 1'b1; we[1] = 1'b1; a[1] = 5'h10; di[1] = 8'h77;
    tick();
    @(negedge clk);
    n_chk++;
    if (o_gnt[0] !== 2'b10) begin n_fail++; $display("FAIL rstmid_owned got %b want 10", o_gnt[0]); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if ({o_gnt[d], o_rv[d], o_pre[d], o_we[d], o_ca[d], o_cdo[d], o_do[d][0], o_do[d][1]} !== 36'd0) begin
        n_fail++;
        $display("FAIL rstmid_outputs dut%0d got gnt=%b rv=%b pre=%b we=%b a=%h do=%h d0=%h d1=%h want all 0",
                 d, o_gnt[d], o_rv[d], o_pre[d], o_we[d], o_ca[d], o_cdo[d], o_do[d][0], o_do[d][1]);
      end
    end
    req = 2'b00; lock = 2'b00; we = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_random_stress();
    int         wt [2][2];
    logic [1:0] eg, ep;
    logic [4:0] ea;
    logic       ewe;
    logic [7:0] edo;
    do_reset();
    for (int d = 0; d < 2; d++) begin wt[d][0] = 0; wt[d][1] = 0; end
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < 2; k++) begin
        req[k]  = ($urandom_range(0, 9) < 7);
        lock[k] = ($urandom_range(0, 3) == 0);
        we[k]   = $urandom_range(0, 1);
        a[k]    = 5'($urandom);
        di[k]   = 8'($urandom);
      end
      csr_di = 8'($urandom);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        eg  = {m_gnt(d, 1), m_gnt(d, 0)};
        ep  = {m_pre(d, 1), m_pre(d, 0)};
        ea  = eg[0] ? a[0]  : (eg[1] ? a[1]  : 5'd0);
        ewe = eg[0] ? we[0] : (eg[1] ? we[1] : 1'b0);
        edo = eg[0] ? di[0] : (eg[1] ? di[1] : 8'd0);
        n_chk++;
        if ({o_gnt[d], o_rv[d], o_pre[d]} !== {eg, mrv[d], ep}) begin
          n_fail++;
          $display("FAIL rnd_ctrl dut%0d n=%0d got gnt=%b rv=%b pre=%b want gnt=%b rv=%b pre=%b",
                   d, n, o_gnt[d], o_rv[d], o_pre[d], eg, mrv[d], ep);
        end
        n_chk++;
        if ({o_ca[d], o_we[d], o_cdo[d]} !== {ea, ewe, edo}) begin
          n_fail++;
          $display("FAIL rnd_bus dut%0d n=%0d got a=%h we=%b do=%h want a=%h we=%b do=%h",
                   d, n, o_ca[d], o_we[d], o_cdo[d], ea, ewe, edo);
        end
        for (int k = 0; k < 2; k++) begin
          if (mrv[d][k]) begin
            n_chk++;
            if (o_do[d][k] !== mdo[d][k]) begin
              n_fail++;
              $display("FAIL rnd_rdata dut%0d m%0d n=%0d got %h want %h", d, k, n, o_do[d][k], mdo[d][k]);
            end
          end
        end
        n_chk++;
        if ((o_gnt[d] === 2'b11) || (o_we[d] === 1'b1 && o_gnt[d] === 2'b00)) begin
          n_fail++;
          $display("FAIL rnd_invariant dut%0d n=%0d got gnt=%b we=%b want one-hot gnt and we only with gnt",
                   d, n, o_gnt[d], o_we[d]);
        end
        for (int k = 0; k < 2; k++) begin
          if (rst || !req[k] || o_gnt[d][k]) wt[d][k] = 0;
          else wt[d][k]++;
          n_chk++;
          if (wt[d][k] > mh[d] + 2) begin
            n_fail++;
            $display("FAIL rnd_starve dut%0d m%0d n=%0d got wait=%0d want <=%0d", d, k, n, wt[d][k], mh[d] + 2);
          end
        end
      end
      tick();
    end
    rst = 1'b0;
    do_reset();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout got no finish want finish before 1000000");
    $fatal(1, "timeout");
  end

  initial begin
    mh[0] = 32; mh[1] = 4;
    for (int d = 0; d < 2; d++) begin
      mown[d] = -1; mlast[d] = 1; mwait[d] = 0; mrv[d] = 2'b00;
      mdo[d][0] = 8'd0; mdo[d][1] = 8'd0;
    end
    rst = 1'b1;
    req = 2'b00; lock = 2'b00; we = 2'b00;
    a[0] = 5'd0; a[1] = 5'd0; di[0] = 8'd0; di[1] = 8'd0; csr_di = 8'd0;
    test_reset();
    test_read_latency();
    test_alternate();
    test_locked_burst();
    test_hold_limit();
    test_reset_mid_burst();
    test_random_stress();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
